// File: rtl/mem_io_responder.sv
// Responder side of the CPU byte bus: RAM with 1-cycle read latency plus the
// I/O window at mem_a[17:16]==2'b11 (UART RX/TX queues, cycle counter, stop flag).
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 16,
  parameter int RX_DEPTH       = 16,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);

  logic [17:0] a;
  logic        io;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic        unused_hi;
  assign a         = mem_a[17:0];
  assign unused_hi = ^mem_a[31:18];
  assign io        = (a[17:16] == 2'b11);
  assign ram_idx   = mem_a[RAM_ADDR_WIDTH-1:0];

  logic rd_rx, rd_cnt, wr_tx, wr_stop;
  assign rd_rx   = io && !mem_wr && (a == 18'h30000);
  assign rd_cnt  = io && !mem_wr && (a == 18'h30004);
  assign wr_tx   = io &&  mem_wr && (a == 18'h30000) && (mem_dout != 8'h00);
  assign wr_stop = io &&  mem_wr && (a == 18'h30004);

  logic [7:0]  ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0]  tx_mem [0:TX_DEPTH-1];
  logic [7:0]  rx_mem [0:RX_DEPTH-1];

  logic [7:0]     mem_din_q, rdata_d;
  logic [31:0]    cnt_q, snap_q;
  logic           done_q, ovf_q, ibf_q, ibf_d;
  logic [TXW-1:0] tx_wp_q, tx_rp_q;
  logic [TXW:0]   tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_wp_q, rx_rp_q;
  logic [RXW:0]   rx_cnt_q;

  logic tx_full, tx_pop, tx_push_req, tx_push;
  logic rx_empty, rx_full, rx_pop, rx_push;
  logic [7:0] tx_push_data;

  assign tx_valid     = (tx_cnt_q != '0);
  assign tx_data      = tx_mem[tx_rp_q];
  assign tx_full      = (tx_cnt_q == TX_FULL_CNT);
  assign tx_pop       = tx_valid && tx_ready;
  assign tx_push_req  = wr_tx || wr_stop;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign tx_push      = tx_push_req && (!tx_full || tx_pop);
  assign tx_push_data = wr_stop ? 8'h00 : mem_dout;
  assign tx_cnt_d     = tx_cnt_q + {{TXW{1'b0}}, tx_push} - {{TXW{1'b0}}, tx_pop};
  assign ibf_d        = ((TX_FULL_CNT - tx_cnt_d) <= (TXW+1)'(FULL_MARGIN));

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign rx_pop   = rd_rx && !rx_empty;
  assign rx_push  = rx_valid && (!rx_full || rx_pop);

  always_comb begin
    rdata_d = 8'h00;
    if (!io) rdata_d = ram[ram_idx];
    else begin
      case (a)
        18'h30000: rdata_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
        18'h30004: rdata_d = cnt_q[7:0];
        18'h30005: rdata_d = snap_q[15:8];
        18'h30006: rdata_d = snap_q[23:16];
        18'h30007: rdata_d = snap_q[31:24];
        default:   rdata_d = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset; only pointers/counts define their contents.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io) ram[ram_idx] <= mem_dout;
    if (tx_push) tx_mem[tx_wp_q] <= tx_push_data;
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q <= 8'h00;
      cnt_q     <= '0;
      snap_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ibf_q     <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (!mem_wr) mem_din_q <= rdata_d;
      cnt_q <= cnt_q + 32'd1;
      if (rd_cnt)  snap_q <= cnt_q;
      if (wr_stop) done_q <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop) ovf_q <= 1'b1;
      ibf_q    <= ibf_d;
      tx_cnt_q <= tx_cnt_d;
      if (tx_push) tx_wp_q <= tx_wp_q + TXW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TXW'(1);
      rx_cnt_q <= rx_cnt_q + {{RXW{1'b0}}, rx_push} - {{RXW{1'b0}}, rx_pop};
      if (rx_push) rx_wp_q <= rx_wp_q + RXW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RXW'(1);
    end
  end

  assign mem_din        = mem_din_q;
  assign io_buffer_full = ibf_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX/TX queues, stop flag, snapshot, async reset.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_done;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .program_done(program_done),
    .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    mem_a  = 32'h0003_0010;
    mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if ({program_done, tx_overflow, io_buffer_full} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {program_done, tx_overflow, io_buffer_full}); end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    mem_a = 32'h0000_0123; mem_dout = 8'hA5; mem_wr = 1'b1; cyc();
    mem_wr = 1'b0; cyc();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_raw got=%h exp=a5", mem_din); end
    mem_a = 32'h0002_0123; cyc();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_alias got=%h exp=a5", mem_din); end
    mem_a = 32'h0001_FFFF; mem_dout = 8'h5A; mem_wr = 1'b1; cyc();
    mem_wr = 1'b0; cyc();
    total++; if (mem_din !== 8'h5A) begin bad++; $display("FAIL ram_top got=%h exp=5a", mem_din); end
    idle();
  endtask

  task automatic test_rx();
    logic [7:0] exp [3];
    exp = '{8'h41, 8'h42, 8'h00};
    rx_valid = 1'b1; rx_data = 8'h41; cyc();
    rx_data = 8'h42; cyc();
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_a = 32'h0003_0000; cyc();
      total++; if (mem_din !== exp[i]) begin bad++; $display("FAIL rx_read%0d got=%h exp=%h", i, mem_din, exp[i]); end
    end
    // empty-queue read with a concurrent push: read gives 0, byte is kept
    rx_valid = 1'b1; rx_data = 8'h55; cyc();
    rx_valid = 1'b0;
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rx_empty_push got=%h exp=00", mem_din); end
    cyc();
    total++; if (mem_din !== 8'h55) begin bad++; $display("FAIL rx_retained got=%h exp=55", mem_din); end
    idle();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'h61 + 8'(i);
      mem_a = 32'h0003_0000; mem_dout = d; mem_wr = 1'b1; cyc();
    end
    total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b exp=1", io_buffer_full); end
    mem_dout = 8'h71; tx_ready = 1'b1; cyc();
    idle();
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL fpp_no_ovf got=%b exp=0", tx_overflow); end
    for (int i = 0; i < 16; i++) begin
      d = 8'h62 + 8'(i);
      total++; if (tx_valid !== 1'b1 || tx_data !== d) begin
        bad++; $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, d); end
      cyc();
    end
    total++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      bad++; $display("FAIL fpp_empty got=%b/%b exp=0/0", tx_valid, io_buffer_full); end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_fill();
    logic [7:0] d;
    logic       e;
    for (int i = 0; i < 16; i++) begin
      d = 8'h31 + 8'(i);
      mem_a = 32'h0003_0000; mem_dout = d; mem_wr = 1'b1; cyc();
      e = (i + 1 >= 14);
      total++; if (io_buffer_full !== e) begin bad++; $display("FAIL fill_ibf%0d got=%b exp=%b", i, io_buffer_full, e); end
    end
    mem_dout = 8'h41; cyc();
    idle();
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", tx_overflow); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = 8'h31 + 8'(i);
      total++; if (tx_valid !== 1'b1 || tx_data !== d) begin
        bad++; $display("FAIL fill_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, d); end
      cyc();
      e = (i + 1 <= 2);
      total++; if (io_buffer_full !== e) begin bad++; $display("FAIL drain_ibf%0d got=%b exp=%b", i, io_buffer_full, e); end
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_stop();
    total++; if (program_done !== 1'b0) begin bad++; $display("FAIL stop_pre got=%b exp=0", program_done); end
    mem_a = 32'h0003_0000; mem_dout = 8'h00; mem_wr = 1'b1; cyc();
    idle();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL zero_ignored got=%b exp=0", tx_valid); end
    mem_a = 32'h0003_0004; mem_dout = 8'h77; mem_wr = 1'b1; cyc();
    idle();
    total++; if (program_done !== 1'b1) begin bad++; $display("FAIL stop_done got=%b exp=1", program_done); end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      bad++; $display("FAIL stop_tx got=%b/%h exp=1/00", tx_valid, tx_data); end
    tx_ready = 1'b1; cyc();
    tx_ready = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL stop_popped got=%b exp=0", tx_valid); end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp [4];
    exp = '{8'h2C, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      mem_a = 32'h0003_0000; mem_dout = 8'h81 + 8'(i); mem_wr = 1'b1; cyc();
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h91 + 8'(i); mem_a = 32'h0000_0123; mem_wr = 1'b0; cyc();
    end
    rx_valid = 1'b0;
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL pre_rst_din got=%h exp=a5", mem_din); end
    idle();
    #2 rst_in = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0 || mem_din !== 8'h00) begin
      bad++; $display("FAIL arst_out got=%b/%h exp=0/00", tx_valid, mem_din); end
    total++; if ({program_done, tx_overflow, io_buffer_full} !== 3'b000) begin
      bad++; $display("FAIL arst_flags got=%b exp=000", {program_done, tx_overflow, io_buffer_full}); end
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (300) @(posedge clk_in);
    @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      mem_a = 32'h0003_0004 + 32'(i); cyc();
      total++; if (mem_din !== exp[i]) begin bad++; $display("FAIL snap_b%0d got=%h exp=%h", i, mem_din, exp[i]); end
    end
    mem_a = 32'h0003_0000; cyc();
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rx_cleared got=%h exp=00", mem_din); end
    mem_a = 32'h0000_0123; cyc();
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_kept got=%h exp=a5", mem_din); end
    idle();
  endtask

  initial begin
    rst_in = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; mem_dout = 8'h00;
    idle();
    test_reset();
    test_ram();
    test_rx();
    test_full_push_pop();
    test_tx_fill();
    test_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
